// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//
// Shares a single iterative CORDIC core between NREQ requesters. Requests are
// granted round-robin with only one operation in flight. The winning request's
// mode and operands are latched and held on the core_* outputs for the whole
// core run. The core gets a one-cycle start pulse, and its results are captured
// on core_valid. Results go back tagged with the requester index. A watchdog
// aborts the operation (core reset pulse, zero result, error flag) if the core
// never reports done.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          per-requester handshake, ready is one-hot
//   req_mode_op                  per requester: 0 rotation, 1 vectoring
//   req_mode_coord               per requester: 01 circ, 00 lin, 11 hyp
//                                (2 bits each)
//   req_x/y/z                    per-requester Q16.16 operands (WIDTH bits each)
//   rsp_valid/rsp_ready          result handshake, result held until accepted
//   rsp_id                       index of the requester the result belongs to
//   rsp_err                      1 when the watchdog aborted the operation
//   rsp_x/y/z                    captured core results (zero on abort)
//   core_rst                     active-high reset to the core
//   core_enable                  one-cycle start pulse to the core
//   core_mode_op/coord           latched mode for the core
//   core_x/y/z                   latched operands for the core
//   core_x/y/z_out, core_valid   core results and done pulse
// -----------------------------------------------------------------------------
module cordic_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_mode_op,
  input  logic [2*NREQ-1:0]       req_mode_coord,
  input  logic [WIDTH*NREQ-1:0]   req_x,
  input  logic [WIDTH*NREQ-1:0]   req_y,
  input  logic [WIDTH*NREQ-1:0]   req_z,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic                    rsp_err,
  output logic [WIDTH-1:0]        rsp_x,
  output logic [WIDTH-1:0]        rsp_y,
  output logic [WIDTH-1:0]        rsp_z,
  output logic                    core_rst,
  output logic                    core_enable,
  output logic                    core_mode_op,
  output logic [1:0]              core_mode_coord,
  output logic [WIDTH-1:0]        core_x,
  output logic [WIDTH-1:0]        core_y,
  output logic [WIDTH-1:0]        core_z,
  input  logic [WIDTH-1:0]        core_x_out,
  input  logic [WIDTH-1:0]        core_y_out,
  input  logic [WIDTH-1:0]        core_z_out,
  input  logic                    core_valid
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_ABORT,
    ST_RESPOND
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant;
  logic             grant_found;
  logic [CNT_W-1:0] wd_cnt;

  // Round-robin pick: scan the requesters starting one past the previous
  // winner and wrapping around, so that a requester which keeps its request
  // up is reached within NREQ operations. A requester that drops its request
  // before being picked loses nothing, because only last_grant moves the
  // starting point.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_s;
    grant       = last_grant;
    grant_found = 1'b0;
    idx         = 0;
    idx_s       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_s = idx[IDW-1:0];
      if (!grant_found && req_valid[idx_s]) begin
        grant       = idx_s;
        grant_found = 1'b1;
      end
    end
  end

  // The accept is offered only while idle. It is also held off during reset,
  // so that every output except core_rst reads zero while rst_n is low.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == ST_IDLE) && grant_found) req_ready[grant] = 1'b1;
  end

  // The core is held in reset with the block and pulsed once on a watchdog
  // abort, so that a hung core starts clean for the next operation.
  assign core_rst = ~rst_n | (state == ST_ABORT);

  // Main sequencer. The operand latches feed the core directly and only
  // change on a new grant, so they are stable from launch until the response
  // is consumed. core_enable and rsp_valid are registered alongside the state
  // so they match LAUNCH and RESPOND exactly. RESPOND always returns through
  // IDLE, which gives the core at least one idle cycle between starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      last_grant      <= IDW'(NREQ - 1);
      wd_cnt          <= '0;
      core_enable     <= 1'b0;
      core_mode_op    <= 1'b0;
      core_mode_coord <= 2'b00;
      core_x          <= '0;
      core_y          <= '0;
      core_z          <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_err         <= 1'b0;
      rsp_x           <= '0;
      rsp_y           <= '0;
      rsp_z           <= '0;
    end else begin
      core_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            core_mode_op    <= req_mode_op[grant];
            core_mode_coord <= req_mode_coord[2*grant +: 2];
            core_x          <= req_x[WIDTH*grant +: WIDTH];
            core_y          <= req_y[WIDTH*grant +: WIDTH];
            core_z          <= req_z[WIDTH*grant +: WIDTH];
            rsp_id          <= grant;
            last_grant      <= grant;
            core_enable     <= 1'b1;
            state           <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_valid) begin
            rsp_x     <= core_x_out;
            rsp_y     <= core_y_out;
            rsp_z     <= core_z_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESPOND;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_x   <= '0;
            rsp_y   <= '0;
            rsp_z   <= '0;
            rsp_err <= 1'b1;
            state   <= ST_ABORT;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_ABORT: begin
          rsp_valid <= 1'b1;
          state     <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_arbiter
//
// Self-checking bench for cordic_arbiter. A behavioural core stand-in answers
// start pulses after a programmable latency, or never answers when it is told
// to hang. The bench first applies a table of single operations with known
// answers. It then runs hand-written sequences for round-robin order, watchdog
// abort, response back-pressure and reset in the middle of an operation.
// Finally it runs a randomized phase against a transaction-level reference
// model.
// -----------------------------------------------------------------------------
module tb_cordic_arbiter;

  localparam int  NREQ        = 4;
  localparam int  WIDTH       = 32;
  localparam int  TIMEOUT     = 64;
  localparam int  RAND_CYCLES = 2000;
  localparam real AN          = 1.6467602581210654;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_mode_op = '0;
  logic [2*NREQ-1:0]     req_mode_coord = '0;
  logic [WIDTH*NREQ-1:0] req_x = '0;
  logic [WIDTH*NREQ-1:0] req_y = '0;
  logic [WIDTH*NREQ-1:0] req_z = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic                  rsp_err;
  logic [WIDTH-1:0]      rsp_x, rsp_y, rsp_z;
  logic                  core_rst, core_enable, core_mode_op;
  logic [1:0]            core_mode_coord;
  logic [WIDTH-1:0]      core_x, core_y, core_z;
  logic [WIDTH-1:0]      core_x_out = '0;
  logic [WIDTH-1:0]      core_y_out = '0;
  logic [WIDTH-1:0]      core_z_out = '0;
  logic                  core_valid = 1'b0;

  int checks   = 0;
  int failures = 0;

  cordic_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode_op(req_mode_op), .req_mode_coord(req_mode_coord),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .core_rst(core_rst), .core_enable(core_enable),
    .core_mode_op(core_mode_op), .core_mode_coord(core_mode_coord),
    .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_x_out(core_x_out), .core_y_out(core_y_out), .core_z_out(core_z_out),
    .core_valid(core_valid)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Ideal core answer. Circular and linear rotation use real arithmetic,
  // including the circular CORDIC gain. The remaining modes use a simple
  // reversible scramble, which is enough to prove the operands and results
  // are routed correctly.
  function automatic void core_fn(input logic op, input logic [1:0] coord,
                                  input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] z, output logic [31:0] xo,
                                  output logic [31:0] yo, output logic [31:0] zo);
    real    zr;
    longint p;
    if (!op && coord == 2'b01) begin
      zr = real'($signed(z)) / 65536.0;
      xo = 32'($rtoi(AN * (real'($signed(x)) * $cos(zr) - real'($signed(y)) * $sin(zr))));
      yo = 32'($rtoi(AN * (real'($signed(y)) * $cos(zr) + real'($signed(x)) * $sin(zr))));
      zo = '0;
    end else if (!op && coord == 2'b00) begin
      p  = longint'($signed(x)) * longint'($signed(z));
      xo = x;
      yo = y + 32'(p >>> 16);
      zo = '0;
    end else begin
      xo = x ^ 32'h5A5A0000;
      yo = y + z;
      zo = ~z;
    end
  endfunction

  // Behavioural core. It starts on core_enable and raises core_valid for one
  // cycle after core_lat further cycles, unless it is hanging. core_rst
  // flushes it. A requested spurious pulse carries junk data so that the
  // arbiter can be seen ignoring core_valid outside WAIT.
  int          core_lat  = 0;
  int          core_cd   = 0;
  bit          core_busy = 1'b0;
  bit          core_hang = 1'b0;
  bit          spurious  = 1'b0;
  logic [31:0] res_x, res_y, res_z;
  int          en_count  = 0;

  always @(negedge clk) begin
    if (core_enable) en_count++;
    if (core_rst) begin
      core_valid = 1'b0;
      core_busy  = 1'b0;
    end else begin
      core_valid = 1'b0;
      if (spurious) begin
        spurious   = 1'b0;
        core_valid = 1'b1;
        core_x_out = 32'hDEADBEEF;
        core_y_out = 32'hDEADBEEF;
        core_z_out = 32'hDEADBEEF;
      end else if (core_enable) begin
        core_busy = 1'b1;
        core_cd   = core_lat;
        core_fn(core_mode_op, core_mode_coord, core_x, core_y, core_z, res_x, res_y, res_z);
      end else if (core_busy && !core_hang) begin
        if (core_cd == 0) begin
          core_valid = 1'b1;
          core_busy  = 1'b0;
          core_x_out = res_x;
          core_y_out = res_y;
          core_z_out = res_z;
        end else begin
          core_cd--;
        end
      end
    end
  end

  // Exact comparison, counted and reported.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Signed comparison with tolerance, for the real-valued core answers.
  task automatic checkNear(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    int d;
    checks++;
    d = $signed(act) - $signed(exp);
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d +-%0d", name, $signed(act), $signed(exp), tol);
    end
  endtask

  // A bounded wait ran out.
  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  typedef struct {
    int          id;
    logic        op;
    logic [1:0]  coord;
    logic [31:0] x, y, z;
    logic [31:0] ex, ey, ez;
    int          tol;
  } vec_t;

  vec_t vecs[6];

  // Loads one requester's payload.
  task automatic loadReq(input int id, input logic op, input logic [1:0] coord,
                         input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    req_mode_op[id]           = op;
    req_mode_coord[2*id +: 2] = coord;
    req_x[32*id +: 32]        = x;
    req_y[32*id +: 32]        = y;
    req_z[32*id +: 32]        = z;
  endtask

  // Runs one operation from a single requester with rsp_ready high and
  // returns what came back. It is entered and left just after a rising edge.
  task automatic applyStimulus(input vec_t v, output logic [31:0] ax, output logic [31:0] ay,
                               output logic [31:0] az, output logic [1:0] aid,
                               output logic aerr, output bit ok);
    int n;
    ok = 1'b0; ax = '0; ay = '0; az = '0; aid = '0; aerr = 1'b0;
    loadReq(v.id, v.op, v.coord, v.x, v.y, v.z);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    rsp_ready       = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[v.id]) break;
    end
    if (n == 20) begin
      timeoutFail("accept");
      req_valid = '0;
      return;
    end
    @(posedge clk); #1;
    req_valid = '0;
    for (n = 0; n < TIMEOUT + 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (n == TIMEOUT + 20) begin
      timeoutFail("response");
      return;
    end
    ax = rsp_x; ay = rsp_y; az = rsp_z; aid = rsp_id; aerr = rsp_err;
    ok = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reset pulse of one cycle, applied and released at falling edges.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] randOperand();
    return 32'($urandom_range(0, 2 ** 21)) - 32'(2 ** 20);
  endfunction

  // Watchdog on the whole run.
  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL global_timeout: bench did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  logic [31:0] ax, ay, az, cap_x, cap_y, cap_z;
  logic [1:0]  aid;
  logic        aerr;
  bit          ok;
  int          n, en0, ng, cnt;
  int          grants[5];
  int          exp_order[5] = '{0, 1, 2, 3, 0};
  vec_t        v;

  // Randomized-phase model state: whether an operation is outstanding, the
  // last requester served, and the payload of the operation in flight.
  bit          outstanding, expect_en, accept, hs, drain;
  int          model_last, exp_idx, c, ops;
  logic [NREQ-1:0] exp_ready;
  int          pend_id;
  logic        pend_op;
  logic [1:0]  pend_coord;
  logic [31:0] pend_x, pend_y, pend_z, ex, ey, ez;

  initial begin
    vecs[0] = '{id:0, op:1'b0, coord:2'b01, x:32'd39797, y:32'd0, z:32'd34315,
                ex:32'd56756, ey:32'd32768, ez:32'd0, tol:16};
    vecs[1] = '{id:2, op:1'b0, coord:2'b00, x:32'h00020000, y:32'd0, z:32'h00030000,
                ex:32'h00020000, ey:32'h00060000, ez:32'd0, tol:4};
    vecs[2] = '{id:1, op:1'b0, coord:2'b00, x:32'h00010000, y:32'h00050000, z:32'hFFFE0000,
                ex:32'h00010000, ey:32'h00030000, ez:32'd0, tol:4};
    vecs[3] = '{id:3, op:1'b1, coord:2'b01, x:32'h00010000, y:32'h00020000, z:32'h00030000,
                ex:32'h5A5B0000, ey:32'h00050000, ez:32'hFFFCFFFF, tol:0};
    vecs[4] = '{id:0, op:1'b0, coord:2'b11, x:32'h00123456, y:32'h00000100, z:32'h00000200,
                ex:32'h5A483456, ey:32'h00000300, ez:32'hFFFFFDFF, tol:0};
    vecs[5] = '{id:2, op:1'b1, coord:2'b00, x:32'd7, y:32'd8, z:32'd9,
                ex:32'h5A5A0007, ey:32'd17, ez:32'hFFFFFFF6, tol:0};

    // Reset state, with every requester asking so that the accept gating is
    // exercised.
    req_valid = '1;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_core_enable", 32'(core_enable), 32'd0);
    checkOutput("rst_core_rst", 32'(core_rst), 32'd1);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_x", rsp_x, 32'd0);
    checkOutput("rst_core_x", core_x, 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("run_core_rst", 32'(core_rst), 32'd0);

    // Table of single operations with known answers.
    core_lat = 2;
    for (int i = 0; i < 6; i++) begin
      en0 = en_count;
      applyStimulus(vecs[i], ax, ay, az, aid, aerr, ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d_id", i), 32'(aid), 32'(vecs[i].id));
        checkOutput($sformatf("vec%0d_err", i), 32'(aerr), 32'd0);
        checkNear($sformatf("vec%0d_x", i), ax, vecs[i].ex, vecs[i].tol);
        checkNear($sformatf("vec%0d_y", i), ay, vecs[i].ey, vecs[i].tol);
        checkNear($sformatf("vec%0d_z", i), az, vecs[i].ez, vecs[i].tol);
        checkOutput($sformatf("vec%0d_enable_cycles", i), 32'(en_count - en0), 32'd1);
      end
    end

    // Round-robin order with everybody requesting: the first grant after
    // reset goes to requester 0.
    doReset();
    core_lat = 1;
    for (int i = 0; i < NREQ; i++) loadReq(i, 1'b1, 2'b11, 32'(i), 32'd0, 32'd0);
    req_valid = '1;
    rsp_ready = 1'b1;
    ng = 0;
    for (int cy = 0; cy < 200 && ng < 5; cy++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        checkOutput("rr_onehot", 32'($countones(req_ready)), 32'd1);
        for (int b = NREQ - 1; b >= 0; b--) if (req_ready[b]) grants[ng] = b;
        ng++;
      end
    end
    if (ng < 5) timeoutFail("rr_grants");
    else for (int i = 0; i < 5; i++) checkOutput($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (12) @(negedge clk);
    @(posedge clk); #1;

    // Hung core: TIMEOUT cycles in WAIT, then one ABORT cycle with core_rst,
    // then an error response with zeroed results.
    core_hang = 1'b1;
    rsp_ready = 1'b0;
    loadReq(0, 1'b0, 2'b01, 32'd39797, 32'd0, 32'd34315);
    req_valid = 4'b0001;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (core_enable) break;
    end
    if (n == 20) timeoutFail("hang_launch");
    @(posedge clk); #1;
    req_valid = '0;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (core_rst) break;
      checkOutput("hang_no_rsp", 32'(rsp_valid), 32'd0);
      n++;
    end
    checkOutput("hang_abort_cycle", 32'(n), 32'(TIMEOUT + 1));
    @(negedge clk);
    checkOutput("hang_core_rst_pulse", 32'(core_rst), 32'd0);
    checkOutput("hang_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("hang_rsp_err", 32'(rsp_err), 32'd1);
    checkOutput("hang_rsp_x", rsp_x, 32'd0);
    checkOutput("hang_rsp_y", rsp_y, 32'd0);
    checkOutput("hang_rsp_z", rsp_z, 32'd0);
    checkOutput("hang_rsp_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    core_hang = 1'b0;

    // Back-pressure: rsp_ready held low for 10 cycles with requester 1
    // pending. The response must hold still, no accept may be offered, and a
    // stray core_valid must be ignored.
    core_lat = 3;
    loadReq(0, 1'b0, 2'b00, 32'h00010000, 32'd0, 32'h00010000);
    loadReq(1, 1'b0, 2'b00, 32'h00030000, 32'h00010000, 32'h00020000);
    req_valid = 4'b0001;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[0]) break;
    end
    if (n == 20) timeoutFail("hold_accept");
    @(posedge clk); #1;
    req_valid = 4'b0010;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (n == 40) timeoutFail("hold_rsp");
    cap_x = rsp_x; cap_y = rsp_y; cap_z = rsp_z;
    checkOutput("hold_first_y", cap_y, 32'h00010000);
    checkOutput("hold_first_id", 32'(rsp_id), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 2) spurious = 1'b1;
      @(negedge clk);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_rsp_x", rsp_x, cap_x);
      checkOutput("hold_rsp_y", rsp_y, cap_y);
      checkOutput("hold_rsp_z", rsp_z, cap_z);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_next_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (n == 40) timeoutFail("hold_second_rsp");
    checkOutput("hold_second_id", 32'(rsp_id), 32'd1);
    checkOutput("hold_second_y", rsp_y, 32'h00070000);
    @(posedge clk); #1;

    // Reset in the middle of WAIT: the operation is dropped without a
    // response, and the next request is served normally.
    core_lat = 30;
    loadReq(3, 1'b0, 2'b00, 32'h00010000, 32'd0, 32'h00010000);
    req_valid = 4'b1000;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (core_enable) break;
    end
    if (n == 20) timeoutFail("mid_launch");
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_core_rst", 32'(core_rst), 32'd1);
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_core_enable", 32'(core_enable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    checkOutput("mid_no_rsp", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    core_lat = 2;
    v = vecs[0];
    v.id = 3;
    applyStimulus(v, ax, ay, az, aid, aerr, ok);
    if (ok) begin
      checkOutput("mid_after_id", 32'(aid), 32'd3);
      checkNear("mid_after_x", ax, 32'd56756, 16);
      checkNear("mid_after_y", ay, 32'd32768, 16);
    end

    // Randomized traffic checked against the transaction-level model.
    doReset();
    outstanding = 1'b0;
    expect_en   = 1'b0;
    model_last  = NREQ - 1;
    ops         = 0;
    pend_id = 0; pend_op = 1'b0; pend_coord = 2'b00;
    pend_x = '0; pend_y = '0; pend_z = '0;
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      drain = (cyc >= RAND_CYCLES - 100);
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
        loadReq(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                randOperand(), randOperand(), randOperand());
      end
      rsp_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      core_lat  = $urandom_range(0, 8);
      @(negedge clk);
      exp_ready = '0;
      exp_idx   = -1;
      if (!outstanding) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (model_last + k) % NREQ;
          if (exp_idx < 0 && req_valid[c]) exp_idx = c;
        end
      end
      if (exp_idx >= 0) exp_ready[exp_idx] = 1'b1;
      checkOutput("rand_req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("rand_core_enable", 32'(core_enable), 32'(expect_en));
      if (expect_en) begin
        checkOutput("rand_core_x", core_x, pend_x);
        checkOutput("rand_core_y", core_y, pend_y);
        checkOutput("rand_core_z", core_z, pend_z);
        checkOutput("rand_core_mode", 32'({core_mode_op, core_mode_coord}), 32'({pend_op, pend_coord}));
      end
      if (rsp_valid) checkOutput("rand_rsp_owner", 32'(outstanding), 32'd1);
      hs = rsp_valid && rsp_ready && outstanding;
      if (hs) begin
        core_fn(pend_op, pend_coord, pend_x, pend_y, pend_z, ex, ey, ez);
        checkOutput("rand_rsp_id", 32'(rsp_id), 32'(pend_id));
        checkOutput("rand_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rand_rsp_x", rsp_x, ex);
        checkOutput("rand_rsp_y", rsp_y, ey);
        checkOutput("rand_rsp_z", rsp_z, ez);
        ops++;
      end
      accept = (exp_idx >= 0);
      if (accept) begin
        pend_id    = exp_idx;
        pend_op    = req_mode_op[exp_idx];
        pend_coord = req_mode_coord[2*exp_idx +: 2];
        pend_x     = req_x[32*exp_idx +: 32];
        pend_y     = req_y[32*exp_idx +: 32];
        pend_z     = req_z[32*exp_idx +: 32];
      end
      @(posedge clk); #1;
      expect_en = accept;
      if (accept) begin
        outstanding = 1'b1;
        model_last  = exp_idx;
      end
      if (hs) outstanding = 1'b0;
    end
    checkOutput("rand_drained", 32'(outstanding), 32'd0);
    checkOutput("rand_ops_done", 32'(ops > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
